// File: rtl/ahb_burst_master_pkg.sv
// Shared AHB-Lite burst-master definitions.
// Contents: transfer/burst/response/size encodings, FSM state type,
// the 1KB address-boundary constant and the beat-count helper.
package ahb_burst_master_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } Trans_t;

  typedef enum logic [2:0] {
    SINGLE = 3'd0,
    INCR   = 3'd1,
    WRAP4  = 3'd2,
    INCR4  = 3'd3,
    WRAP8  = 3'd4,
    INCR8  = 3'd5,
    WRAP16 = 3'd6,
    INCR16 = 3'd7
  } BType_t;

  typedef enum logic {
    OKAY  = 1'b0,
    ERROR = 1'b1
  } Response_t;

  typedef enum logic [2:0] {
    BYTE       = 3'd0,
    HALFWORD   = 3'd1,
    WORD       = 3'd2,
    DOUBLEWORD = 3'd3,
    LINE4      = 3'd4,
    LINE8      = 3'd5,
    WORD512    = 3'd6,
    WORD1024   = 3'd7
  } Size_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_XFER  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam int unsigned KB_BOUNDARY = 1024;

  function automatic logic is_wrap(BType_t b);
    return (b == WRAP4) || (b == WRAP8) || (b == WRAP16);
  endfunction

  // Undefined-length INCR uses len (0 means one beat); clamping to the
  // configured maximum is left to the instantiating block.
  function automatic logic [7:0] beats_of(BType_t b, logic [7:0] len);
    logic [7:0] n;
    n = 8'd1;
    case (b)
      SINGLE:         n = 8'd1;
      INCR:           n = (len == 8'd0) ? 8'd1 : len;
      WRAP4, INCR4:   n = 8'd4;
      WRAP8, INCR8:   n = 8'd8;
      WRAP16, INCR16: n = 8'd16;
      default:        n = 8'd1;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/ahb_addr_next.sv
// Combinational next-beat address generator for AHB-Lite bursts.
// Ports:
//   addr_i        current beat address
//   burst_i       burst type in force for this beat
//   size_i        transfer size code
//   next_o        address of the following beat
//   crosses_1kb_o next address of an incrementing burst sits on a 1KB boundary
module ahb_addr_next
  import ahb_burst_master_pkg::*;
#(
  parameter int unsigned ADDRWIDTH = 32
) (
  input  logic [ADDRWIDTH-1:0] addr_i,
  input  BType_t               burst_i,
  input  logic [2:0]           size_i,
  output logic [ADDRWIDTH-1:0] next_o,
  output logic                 crosses_1kb_o
);

  localparam int unsigned KB_BITS = $clog2(KB_BOUNDARY);

  logic [ADDRWIDTH-1:0] inc;
  logic [ADDRWIDTH-1:0] sum;
  logic [ADDRWIDTH-1:0] wmask;

  always_comb begin
    inc   = ADDRWIDTH'(1) << size_i;
    sum   = addr_i + inc;
    wmask = '0;
    case (burst_i)
      WRAP4:   wmask = (inc << 2) - ADDRWIDTH'(1);
      WRAP8:   wmask = (inc << 3) - ADDRWIDTH'(1);
      WRAP16:  wmask = (inc << 4) - ADDRWIDTH'(1);
      default: wmask = '0;
    endcase
    if (is_wrap(burst_i)) begin
      next_o        = (addr_i & ~wmask) | (sum & wmask);
      crosses_1kb_o = 1'b0;
    end else begin
      next_o        = sum;
      crosses_1kb_o = (sum[KB_BITS-1:0] == '0);
    end
  end

endmodule

// File: rtl/ahb_burst_master.sv
// AHB-Lite master burst sequencer: takes one burst command at a time and
// drives the address-phase signals for every beat, handling wrap bounds,
// 1KB-boundary re-issue as NONSEQ/INCR, wait states and ERROR responses.
// Ports:
//   HCLK, HRESETn                     clock, async active-low reset
//   cmd_valid/cmd_ready               command handshake
//   cmd_addr/burst/size/len/write     command fields (len used for INCR only)
//   HADDR/HTRANS/HBURST/HSIZE/HWRITE  registered address phase
//   HREADY, HRESP                     slave handshake / response
//   beat_done                         pulse per completed data phase
//   err                               pulse on ERROR response or rejected command
// Build option: AHB_ERR_ABORT_EN cancels the remaining beats on ERROR.
module ahb_burst_master
  import ahb_burst_master_pkg::*;
#(
  parameter int unsigned ADDRWIDTH    = 32,
  parameter int unsigned DATAWIDTH    = 32,
  parameter int unsigned MAX_INCR_LEN = 16
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [ADDRWIDTH-1:0] cmd_addr,
  input  logic [2:0]           cmd_burst,
  input  logic [2:0]           cmd_size,
  input  logic [7:0]           cmd_len,
  input  logic                 cmd_write,
  output logic [ADDRWIDTH-1:0] HADDR,
  output logic [1:0]           HTRANS,
  output logic [2:0]           HBURST,
  output logic [2:0]           HSIZE,
  output logic                 HWRITE,
  input  logic                 HREADY,
  input  logic                 HRESP,
  output logic                 beat_done,
  output logic                 err
);

  localparam int unsigned  MAX_SIZE = $clog2(DATAWIDTH / 8);
  localparam logic [7:0]   MAX_LEN8 = 8'(MAX_INCR_LEN);

  state_t               state_q,  state_d;
  logic [ADDRWIDTH-1:0] haddr_q,  haddr_d;
  Trans_t               htrans_q, htrans_d;
  BType_t               hburst_q, hburst_d;
  logic [2:0]           hsize_q,  hsize_d;
  logic                 hwrite_q, hwrite_d;
  logic [7:0]           rem_q,    rem_d;     // beats still to issue after the current one
  logic                 dphase_q, dphase_d;
  logic                 rej_q,    rej_d;

  logic [ADDRWIDTH-1:0] addr_nxt;
  logic                 crosses;
  logic [ADDRWIDTH-1:0] size_mask;
  logic [7:0]           beats;

  ahb_addr_next #(.ADDRWIDTH(ADDRWIDTH)) u_addr_next (
    .addr_i        (haddr_q),
    .burst_i       (hburst_q),
    .size_i        (hsize_q),
    .next_o        (addr_nxt),
    .crosses_1kb_o (crosses)
  );

  always_comb begin
    state_d   = state_q;
    haddr_d   = haddr_q;
    htrans_d  = htrans_q;
    hburst_d  = hburst_q;
    hsize_d   = hsize_q;
    hwrite_d  = hwrite_q;
    rem_d     = rem_q;
    dphase_d  = dphase_q;
    rej_d     = 1'b0;
    size_mask = (ADDRWIDTH'(1) << cmd_size) - ADDRWIDTH'(1);
    beats     = beats_of(BType_t'(cmd_burst), cmd_len);
    if ((BType_t'(cmd_burst) == INCR) && (beats > MAX_LEN8)) beats = MAX_LEN8;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          if (cmd_size > 3'(MAX_SIZE)) begin
            rej_d = 1'b1;
          end else begin
            haddr_d  = cmd_addr & ~size_mask;
            htrans_d = NONSEQ;
            hburst_d = BType_t'(cmd_burst);
            hsize_d  = cmd_size;
            hwrite_d = cmd_write;
            rem_d    = beats - 8'd1;
            state_d  = S_XFER;
          end
        end
      end
      S_XFER: begin
        if (HREADY) begin
          if (rem_q != 8'd0) begin
            haddr_d = addr_nxt;
            rem_d   = rem_q - 8'd1;
            // A 1KB crossing restarts the burst as undefined-length INCR.
            if (crosses) begin
              htrans_d = NONSEQ;
              hburst_d = INCR;
            end else begin
              htrans_d = SEQ;
            end
          end else begin
            htrans_d = IDLE;
            state_d  = S_DRAIN;
          end
        end
`ifdef AHB_ERR_ABORT_EN
        // First ERROR cycle: withdraw the pending address phase immediately.
        else if (dphase_q && (Response_t'(HRESP) == ERROR)) begin
          htrans_d = IDLE;
          rem_d    = '0;
          state_d  = S_DRAIN;
        end
`endif
      end
      S_DRAIN: begin
        if (HREADY) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (HREADY) dphase_d = (htrans_q == NONSEQ) || (htrans_q == SEQ);
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= S_IDLE;
      haddr_q  <= '0;
      htrans_q <= IDLE;
      hburst_q <= SINGLE;
      hsize_q  <= '0;
      hwrite_q <= 1'b0;
      rem_q    <= '0;
      dphase_q <= 1'b0;
      rej_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      haddr_q  <= haddr_d;
      htrans_q <= htrans_d;
      hburst_q <= hburst_d;
      hsize_q  <= hsize_d;
      hwrite_q <= hwrite_d;
      rem_q    <= rem_d;
      dphase_q <= dphase_d;
      rej_q    <= rej_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign HADDR     = haddr_q;
  assign HTRANS    = htrans_q;
  assign HBURST    = hburst_q;
  assign HSIZE     = hsize_q;
  assign HWRITE    = hwrite_q;
  assign beat_done = dphase_q & HREADY;
  // The second ERROR cycle has HREADY=1, so this fires once per response.
  assign err       = rej_q | (dphase_q & HRESP & ~HREADY);

endmodule
